aes_128_key_sched: RTL and testbench
====================================

// Module: aes_128_key_sched
// PURPOSE
//  On-the-fly AES-128 forward key expansion; the round-key responder for aes_128_top.
//  Stores a 128-bit cipher key, presents round key 0, and advances to round key i+1
//  each time the core raises key_ready. Restarts at round key 0 on every new block (in_en).
//  Sits beside aes_128_top; key_round drives the core's key_round input directly.
// PARAMETERS
//  NR      10   number of rounds after round key 0 (AES-128 = 10)
//  KEY_W   128  key/round-key width; only 128 is supported
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  kill       in   1    reset, asynchronous, active-low
//  key_load   in   1    capture key_in as the new cipher key
//  key_in     in   128  cipher key; byte b of the AES key at bits [8b+7:8b]
//  in_en      in   1    new-block strobe (same signal fed to aes_128_top); rewinds to round 0
//  key_ready  in   1    request from core: advance to next round key
//  key_round  out  128  current round key, same byte order as key_in
//  key_idx    out  4    index of round key on key_round (0..NR)
//  key_valid  out  1    a cipher key is loaded; key_round is meaningful
//  key_err    out  1    one-cycle pulse: key_ready seen in IDLE or DONE
// BEHAVIOUR
//  Reset (kill low): key_round=0, key_idx=0, key_valid=0, key_err=0, stored key=0,
//   rcon=8'h01, state IDLE. Asserting kill mid-round aborts at once; no partial keys kept.
//  States: IDLE (no key), READY (idx 0), RUN (idx 1..NR-1), DONE (idx NR).
//  Priority per edge: key_load > in_en > key_ready.
//  key_load=1 (any state): store key_in; key_round<=key_in; idx<=0; rcon<=01; key_valid<=1;
//   -> READY. An in_en or key_ready on the same edge is ignored.
//  in_en=1 (READY/RUN/DONE, no key_load): key_round<=stored key; idx<=0; rcon<=01 -> READY.
//   A simultaneous key_ready is ignored (the new block uses round key 0 first).
//  key_ready=1 in READY/RUN: key_round<=next(key_round, rcon) at that same edge; idx+1;
//   rcon<=xtime(rcon) (01,02,04,08,10,20,40,80,1b,36). Result is visible the cycle after
//   key_ready is sampled high. READY->RUN; RUN->DONE when the new idx==NR.
//  key_ready=1 in DONE or IDLE: key_round/idx unchanged; key_err=1 for one cycle.
//  key_ready and in_en are level-sampled; each high cycle of key_ready is one advance.
//  next(): words w0..w3 (w0=bits[31:0]); t = SubWord(RotWord(w3)) ^ {24'b0,rcon} in
//   byte-little-endian order, i.e. RotWord takes bytes (b13,b14,b15,b12) of w3 and rcon
//   XORs byte 0 of t; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
//  S-box: four combinational FIPS-197 S-box lookups (case-ROM function); next() is
//   single-cycle combinational from registered key_round and rcon.
//  key_round holds between requests; the core may take any number of cycles per round.
//  in_en is accepted in IDLE with no effect (no key_err).
// TESTING
//  1 key_load key_in=128'h0f0e0d0c0b0a09080706050403020100 -> key_round=key_in, idx=0,
//    key_valid=1; key_ready 1 cycle -> key_round=128'hfe76abd6f178a6dafa72afd2fd74aad6, idx=1.
//  2 Same key, 10 key_ready pulses spaced 3 cycles -> idx=10,
//    key_round=128'hc5302b4d8ba707f3174a94e37f1d1113; 11th pulse -> key_err 1 cycle, key unchanged.
//  3 Key all-zero, 1 key_ready -> 128'h63636362636363626363636263636362; after 10 ->
//    128'h8e188f6fcf51e92311e2923ecb5befb4.
//  4 Mid-schedule (idx=5) in_en with key_ready same edge -> key_round=cipher key, idx=0;
//    rerun 10 requests -> test-1/2 values reproduced exactly.
//  5 key_ready in IDLE after reset -> key_err pulse, outputs stay 0; kill low at idx=3 ->
//    all outputs 0 asynchronously, IDLE; key_load during RUN -> new key at idx 0.
//  6 Closed loop with aes_128_top: in_data=128'hffeeddccbbaa99887766554433221100,
//    key above -> out_data matches FIPS-197 C.1 ciphertext in byte-little-endian order.

Source files
------------

// File: rtl/aes_128_key_sched.sv
// On-the-fly AES-128 forward key expansion: holds the cipher key and steps through
// round keys 0..NR on request from the cipher core, rewinding to round 0 per block.
module aes_128_key_sched #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             kill,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             in_en,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_round,
  output logic [3:0]       key_idx,
  output logic             key_valid,
  output logic             key_err
);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] stored_q, stored_d;
  logic [KEY_W-1:0] round_d;
  logic [3:0]       idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             valid_d, err_d;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 sits in the low bits, so RotWord is a right rotate of w3 by one byte.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, t, w0, w1, w2, w3;
    rot = {k[103:96], k[127:104]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {24'h0, rc};
    w0  = k[31:0]   ^ t;
    w1  = k[63:32]  ^ w0;
    w2  = k[95:64]  ^ w1;
    w3  = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    stored_d = stored_q;
    round_d  = key_round;
    idx_d    = key_idx;
    rcon_d   = rcon_q;
    valid_d  = key_valid;
    err_d    = 1'b0;
    if (key_load) begin
      stored_d = key_in;
      round_d  = key_in;
      idx_d    = 4'd0;
      rcon_d   = 8'h01;
      valid_d  = 1'b1;
      state_d  = S_READY;
    end else if (in_en) begin
      if (state_q != S_IDLE) begin
        round_d = stored_q;
        idx_d   = 4'd0;
        rcon_d  = 8'h01;
        state_d = S_READY;
      end
    end else if (key_ready) begin
      case (state_q)
        S_READY, S_RUN: begin
          round_d = next_key(key_round, rcon_q);
          idx_d   = key_idx + 4'd1;
          rcon_d  = xtime(rcon_q);
          state_d = (idx_d == LAST_IDX) ? S_DONE : S_RUN;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      state_q   <= S_IDLE;
      stored_q  <= '0;
      key_round <= '0;
      key_idx   <= 4'd0;
      rcon_q    <= 8'h01;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stored_q  <= stored_d;
      key_round <= round_d;
      key_idx   <= idx_d;
      rcon_q    <= rcon_d;
      key_valid <= valid_d;
      key_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_128_key_sched.sv
// Directed bench for aes_128_key_sched; expected round keys come from a byte-level
// key-expansion model whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_128_key_sched;

  localparam logic [127:0] K1   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] RK1  = 128'hfe76abd6f178a6dafa72afd2fd74aad6;
  localparam logic [127:0] RK10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
  localparam logic [127:0] Z1   = 128'h63636362636363626363636263636362;
  localparam logic [127:0] Z10  = 128'h8e188f6fcf51e92311e2923ecb5befb4;
  localparam logic [7:0]   RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         valid;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         kill;
  logic         key_load, in_en, key_ready;
  logic [127:0] key_in;
  logic [127:0] key_round;
  logic [3:0]   key_idx;
  logic         key_valid, key_err;

  int checks = 0;
  int errors = 0;

  exp_t  sb_q[$];
  string tag_q[$];

  logic [127:0] m_key, m_stored;
  int           m_idx;
  logic         m_valid;

  aes_128_key_sched dut (
    .clk       (clk),
    .kill      (kill),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_en     (in_en),
    .key_ready (key_ready),
    .key_round (key_round),
    .key_idx   (key_idx),
    .key_valid (key_valid),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand_model(input logic [127:0] k, input logic [7:0] rc);
    logic [7:0] b [16];
    logic [7:0] nb [16];
    logic [7:0] t [4];
    logic [127:0] r;
    for (int j = 0; j < 16; j++) b[j] = k[8*j +: 8];
    t[0] = b[13]; t[1] = b[14]; t[2] = b[15]; t[3] = b[12];
    for (int j = 0; j < 4; j++) t[j] = sbox_model(t[j]);
    t[0] = t[0] ^ rc;
    for (int j = 0; j < 4; j++)  nb[j] = b[j] ^ t[j];
    for (int j = 4; j < 16; j++) nb[j] = b[j] ^ nb[j-4];
    for (int j = 0; j < 16; j++) r[8*j +: 8] = nb[j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: the model predicts the post-edge outputs, the prediction is
  // queued, and it is popped and compared one time unit after the edge.
  task automatic drive(input logic ld, input logic [127:0] kin, input logic en,
                       input logic rdy, input string tag);
    exp_t  e;
    string t;
    logic  err = 1'b0;
    if (ld) begin
      m_stored = kin; m_key = kin; m_idx = 0; m_valid = 1'b1;
    end else if (en) begin
      if (m_valid) begin m_key = m_stored; m_idx = 0; end
    end else if (rdy) begin
      if (!m_valid || m_idx == 10) err = 1'b1;
      else begin m_key = expand_model(m_key, RCON[m_idx]); m_idx++; end
    end
    sb_q.push_back('{key: m_key, idx: 4'(m_idx), valid: m_valid, err: err});
    tag_q.push_back(tag);
    key_load = ld; key_in = kin; in_en = en; key_ready = rdy;
    @(posedge clk);
    #1;
    key_load = 1'b0; in_en = 1'b0; key_ready = 1'b0;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_key"},   key_round,        e.key);
    chk({t, "_idx"},   128'(key_idx),    128'(e.idx));
    chk({t, "_valid"}, 128'(key_valid),  128'(e.valid));
    chk({t, "_err"},   128'(key_err),    128'(e.err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, "idle");
  endtask

  task automatic ready(input string tag);
    drive(1'b0, '0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    kill = 1'b0; key_load = 1'b0; in_en = 1'b0; key_ready = 1'b0; key_in = '0;
    m_key = '0; m_stored = '0; m_idx = 0; m_valid = 1'b0;
    #12;
    chk("rst_key",   key_round,       '0);
    chk("rst_idx",   128'(key_idx),   '0);
    chk("rst_valid", 128'(key_valid), '0);
    chk("rst_err",   128'(key_err),   '0);
    @(negedge clk);
    kill = 1'b1;

    // Requests with no key loaded flag an error; a block strobe is silently accepted.
    ready("idle_rdy");
    idle(1);
    drive(1'b0, '0, 1'b1, 1'b0, "idle_en");

    // Load the FIPS-197 key and walk the whole schedule with spaced requests.
    drive(1'b1, K1, 1'b0, 1'b0, "t1_load");
    ready("t1_rdy");
    chk("t1_rk1_const", key_round, RK1);
    idle(2);
    for (int i = 2; i <= 10; i++) begin
      ready("t2_rdy");
      idle(2);
    end
    chk("t2_rk10_const", key_round, RK10);
    chk("t2_idx10", 128'(key_idx), 128'd10);
    ready("t2_over");
    idle(1);

    // Rewind mid-schedule with a simultaneous request, then replay the schedule.
    drive(1'b0, '0, 1'b1, 1'b0, "t4_en");
    for (int i = 0; i < 5; i++) ready("t4_adv");
    drive(1'b0, '0, 1'b1, 1'b1, "t4_en_rdy");
    chk("t4_rewind_const", key_round, K1);
    for (int i = 0; i < 10; i++) begin
      ready("t4_rerun");
      if (i == 0) chk("t4_rk1_const", key_round, RK1);
    end
    chk("t4_rk10_const", key_round, RK10);

    // A new key during RUN wins over a simultaneous strobe and request.
    drive(1'b0, '0, 1'b1, 1'b0, "t5_en");
    ready("t5_rdy");
    ready("t5_rdy");
    drive(1'b1, '0, 1'b1, 1'b1, "t5_load_run");
    ready("t3_rdy");
    chk("t3_z1_const", key_round, Z1);
    for (int i = 1; i < 10; i++) ready("t3_rdy");
    chk("t3_z10_const", key_round, Z10);

    // Asynchronous kill partway through a schedule.
    drive(1'b1, K1, 1'b0, 1'b0, "t5_load");
    for (int i = 0; i < 3; i++) ready("t5_adv");
    #3 kill = 1'b0;
    #1;
    chk("kill_key",   key_round,       '0);
    chk("kill_idx",   128'(key_idx),   '0);
    chk("kill_valid", 128'(key_valid), '0);
    chk("kill_err",   128'(key_err),   '0);
    m_key = '0; m_stored = '0; m_idx = 0; m_valid = 1'b0;
    #2 kill = 1'b1;
    ready("kill_rdy_idle");
    drive(1'b0, '0, 1'b1, 1'b0, "kill_en_idle");
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
